imem_loader: RTL and testbench

Boot-time programmer for the instruction RAM. It accepts a byte stream from a host link and assembles little-endian 32-bit words, then writes them through the RAM's byte-enable write port. It then reads every word back and checks an additive checksum. The CPU core is held in reset until a load session passes verification.

---
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream to instruction RAM with checksum readback verification
module imem_loader #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic [3:0]        ram_wea,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_hold
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   typedef enum logic [3:0] {
      S_IDLE, S_RECV, S_WRITE, S_CKSUM, S_RD, S_CAP, S_CMP, S_DONE, S_FAIL
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [23:0]       asm_q, asm_d;
   logic [31:0]       exp_q, exp_d;
   logic [31:0]       rx_sum_q, rx_sum_d;
   logic [31:0]       rd_sum_q, rd_sum_d;
   logic              byte_ready_q, byte_ready_d;
   logic [3:0]        ram_wea_q, ram_wea_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_din_q, ram_din_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              cpu_hold_q, cpu_hold_d;

   logic              accept;
   logic [23:0]       asm_fill;
   logic [31:0]       word;

   // Next-state, datapath updates and registered-output targets (outputs follow the next state)
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      bidx_d     = bidx_q;
      asm_d      = asm_q;
      exp_d      = exp_q;
      rx_sum_d   = rx_sum_q;
      rd_sum_d   = rd_sum_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;

      accept   = byte_ready_q && byte_valid;
      word     = {byte_data, asm_q};
      asm_fill = asm_q;
      case (bidx_q)
         2'd0:    asm_fill[7:0]   = byte_data;
         2'd1:    asm_fill[15:8]  = byte_data;
         default: asm_fill[23:16] = byte_data;
      endcase

      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               if (len > DEPTH_L) begin
                  state_d = S_FAIL;
               end else begin
                  // an empty image has no data words, only the checksum
                  state_d  = (len == '0) ? S_CKSUM : S_RECV;
                  len_d    = len;
                  idx_d    = '0;
                  bidx_d   = '0;
                  rx_sum_d = '0;
                  rd_sum_d = '0;
               end
            end
         end
         S_RECV: begin
            if (accept) begin
               if (bidx_q == 2'd3) begin
                  ram_din_d  = word;
                  ram_addr_d = idx_q[ADDR_W-1:0];
                  bidx_d     = '0;
                  state_d    = S_WRITE;
               end else begin
                  asm_d  = asm_fill;
                  bidx_d = bidx_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            rx_sum_d = rx_sum_q + ram_din_q;
            idx_d    = idx_q + 1'b1;
            state_d  = (idx_d < len_q) ? S_RECV : S_CKSUM;
         end
         S_CKSUM: begin
            if (accept) begin
               if (bidx_q == 2'd3) begin
                  exp_d  = word;
                  bidx_d = '0;
                  idx_d  = '0;
                  if (len_q == '0) begin
                     state_d = S_CMP;
                  end else begin
                     state_d    = S_RD;
                     ram_addr_d = '0;
                  end
               end else begin
                  asm_d  = asm_fill;
                  bidx_d = bidx_q + 1'b1;
               end
            end
         end
         S_RD: begin
            state_d = S_CAP;
         end
         S_CAP: begin
            rd_sum_d = rd_sum_q + ram_dout;
            idx_d    = idx_q + 1'b1;
            if (idx_d < len_q) begin
               state_d    = S_RD;
               ram_addr_d = idx_d[ADDR_W-1:0];
            end else begin
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            state_d = (rx_sum_q == exp_q && rd_sum_q == exp_q) ? S_DONE : S_FAIL;
         end
         default: state_d = S_IDLE;
      endcase

      byte_ready_d = (state_d == S_RECV) || (state_d == S_CKSUM);
      ram_wea_d    = (state_d == S_WRITE) ? 4'hF : 4'h0;
      busy_d       = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_FAIL);
      done_d       = (state_d == S_DONE);
      error_d      = (state_d == S_FAIL);
      cpu_hold_d   = (state_d != S_DONE);
   end

   // State, datapath and output registers; reset releases nothing to the CPU
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         idx_q        <= '0;
         bidx_q       <= '0;
         asm_q        <= '0;
         exp_q        <= '0;
         rx_sum_q     <= '0;
         rd_sum_q     <= '0;
         byte_ready_q <= 1'b0;
         ram_wea_q    <= 4'h0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         cpu_hold_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         bidx_q       <= bidx_d;
         asm_q        <= asm_d;
         exp_q        <= exp_d;
         rx_sum_q     <= rx_sum_d;
         rd_sum_q     <= rd_sum_d;
         byte_ready_q <= byte_ready_d;
         ram_wea_q    <= ram_wea_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         cpu_hold_q   <= cpu_hold_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign ram_wea    = ram_wea_q;
   assign ram_addr   = ram_addr_q;
   assign ram_din    = ram_din_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a registered-read RAM model
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [12:0] len = '0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready;
   logic [3:0]  ram_wea;
   logic [11:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout = '0;
   logic        busy, done, error, cpu_hold;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] mem [4096];
   logic [31:0] wbuf [8];
   bit          corrupt = 1'b0;
   bit          gaps = 1'b0;

   typedef struct packed {
      logic [11:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_wq [$];

   imem_loader #(.ADDR_W(12), .DEPTH(1024)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // RAM model: byte-enable writes, registered read, optional bit-0 corruption of word 1
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (ram_wea[k]) mem[ram_addr][8*k +: 8] <= ram_din[8*k +: 8];
      ram_dout <= mem[ram_addr] ^ ((corrupt && ram_addr == 12'd1) ? 32'h1 : 32'h0);
   end

   // Write monitor: every write cycle must match the next expected write
   always @(negedge clk) begin
      if (!rst && ram_wea != 4'h0) begin
         if (exp_wq.size() == 0) begin
            check("unexpected_write", {ram_wea, ram_addr}, 64'h0);
         end else begin
            wr_t e;
            e = exp_wq.pop_front();
            check("wr_wea", ram_wea, 4'hF);
            check("wr_addr", ram_addr, e.a);
            check("wr_din", ram_din, e.d);
         end
      end
   end

   task automatic check_reset_vals();
      check("rst_byte_ready", byte_ready, 0);
      check("rst_ram_wea", ram_wea, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_cpu_hold", cpu_hold, 1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && guard < 50) begin
         check("ready_low_only_in_write", ram_wea, 4'hF);
         @(negedge clk);
         guard++;
      end
      if (!byte_ready) check("ready_timeout", byte_ready, 1);
      @(negedge clk);
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      len   = 13'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_session(input int n, input logic [31:0] ck, input bit pass, input int exp_lat);
      int lat;
      do_start(n);
      check("busy_after_start", busy, 1);
      check("hold_in_session", cpu_hold, 1);
      check("done_cleared", done, 0);
      check("ready_after_start", byte_ready, 1);
      for (int i = 0; i < n; i++) begin
         exp_wq.push_back({12'(i), wbuf[i]});
         for (int b = 0; b < 4; b++) send_byte(wbuf[i][8*b +: 8]);
      end
      for (int b = 0; b < 4; b++) send_byte(ck[8*b +: 8]);
      byte_valid = 1'b0;
      lat = 1;
      while (!(done || error) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("result_latency", lat, exp_lat);
      check("done", done, pass);
      check("error", error, !pass);
      check("cpu_hold", cpu_hold, !pass);
      check("busy_end", busy, 0);
      check("writes_outstanding", exp_wq.size(), 0);
   endtask

   initial begin
      logic [31:0] sum;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      @(negedge clk);

      // happy path
      wbuf[0] = 32'h08004693;
      wbuf[1] = 32'h00001137;
      run_session(2, 32'h080057CA, 1'b1, 6);
      check("mem0", mem[0], 32'h08004693);
      check("mem1", mem[1], 32'h00001137);

      // bad checksum
      run_session(2, 32'h0, 1'b0, 6);

      // readback corruption
      corrupt = 1'b1;
      run_session(2, 32'h080057CA, 1'b0, 6);
      corrupt = 1'b0;

      // empty image
      run_session(0, 32'h0, 1'b1, 2);

      // oversize image
      do_start(1025);
      check("big_error", error, 1);
      check("big_busy", busy, 0);
      check("big_hold", cpu_hold, 1);
      for (int c = 0; c < 6; c++) begin
         byte_valid = 1'b1;
         check("big_ready_low", byte_ready, 0);
         check("big_wea_low", ram_wea, 0);
         @(negedge clk);
      end
      byte_valid = 1'b0;

      // random words with source gaps
      gaps = 1'b1;
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = $urandom;
         sum += wbuf[i];
      end
      run_session(4, sum, 1'b1, 10);
      gaps = 1'b0;
      for (int i = 0; i < 4; i++) check("mem_rand", mem[i], wbuf[i]);

      // reset mid-session after 5 bytes of a len=3 load
      wbuf[0] = 32'hA5A51234;
      wbuf[1] = 32'h0BADF00D;
      do_start(3);
      exp_wq.push_back({12'd0, wbuf[0]});
      for (int b = 0; b < 4; b++) send_byte(wbuf[0][8*b +: 8]);
      send_byte(wbuf[1][7:0]);
      check("mid_busy", busy, 1);
      #2 rst = 1'b1;
      #1 check_reset_vals();
      exp_wq.delete();
      byte_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // restart with len=1
      wbuf[0] = 32'h00000013;
      run_session(1, 32'h00000013, 1'b1, 4);
      check("mem_restart", mem[0], 32'h00000013);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
